// File: rtl/pktstat_collect.sv
// rtl/pktstat_collect.sv - four-tap packet length monitor with round-robin record serializer (optional drop counter: PKTCOLLECT_DROPCNT_EN)
module pktstat_collect #(
  parameter  int DW   = 128,
  localparam int NTAP = 4,
  localparam int BW   = $clog2(DW/8)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NTAP-1:0]      i_tap_valid,
  input  logic [NTAP-1:0]      i_tap_ready,
  input  logic [NTAP-1:0]      i_tap_last,
  input  logic [NTAP-1:0]      i_tap_abort,
  input  logic [NTAP*BW-1:0]   i_tap_bytes,
  output logic                 o_valid,
  output logic [30:0]          o_data,
  output logic [15:0]          o_dropped
);

  localparam logic [16:0] LEN_MAX   = '1;
  localparam logic [17:0] FULL_BEAT = 18'(DW/8);

  logic [16:0]     len_q      [NTAP];
  logic [16:0]     len_d      [NTAP];
  logic [16:0]     pend_len_q [NTAP];
  logic [16:0]     pend_len_d [NTAP];
  logic [16:0]     acc_len    [NTAP];
  logic [16:0]     rec_len    [NTAP];
  logic [NTAP-1:0] inpkt_q, inpkt_d;
  logic [NTAP-1:0] pend_q, pend_d;
  logic [NTAP-1:0] pend_abort_q, pend_abort_d;
  logic [NTAP-1:0] beat, complete, grant;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gnt_idx, scan_idx;
  logic            gnt_any;
  logic            out_valid_q, out_valid_d;
  logic [30:0]     out_data_q, out_data_d;
`ifdef PKTCOLLECT_DROPCNT_EN
  logic [NTAP-1:0] drop;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [16:0]     drop_sum;
`endif

  // Per-tap length accumulation; completion on last beat or on an abort that hits an open packet
  always_comb begin
    beat     = i_tap_valid & i_tap_ready;
    complete = '0;
    for (int t = 0; t < NTAP; t++) begin
      logic [BW-1:0] raw;
      logic [17:0]   sum;
      raw        = i_tap_bytes[t*BW +: BW];
      sum        = {1'b0, len_q[t]} + ((raw == '0) ? FULL_BEAT : 18'(raw));
      acc_len[t] = sum[17] ? LEN_MAX : sum[16:0];
      rec_len[t] = beat[t] ? acc_len[t] : len_q[t];
      complete[t] = (beat[t] && i_tap_last[t]) || (i_tap_abort[t] && (inpkt_q[t] || beat[t]));
      len_d[t]   = len_q[t];
      inpkt_d[t] = inpkt_q[t];
      if (complete[t]) begin
        len_d[t]   = '0;
        inpkt_d[t] = 1'b0;
      end else if (beat[t]) begin
        len_d[t]   = acc_len[t];
        inpkt_d[t] = 1'b1;
      end
    end
  end

  // Round-robin grant: first pending tap at or after the pointer, wrapping
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < NTAP; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!gnt_any && pend_q[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    grant[gnt_idx] = gnt_any;
    ptr_d          = gnt_any ? gnt_idx + 2'd1 : ptr_q;
  end

  // Single-entry pending slot per tap; a full, ungranted slot keeps its old record
  always_comb begin
`ifdef PKTCOLLECT_DROPCNT_EN
    drop = '0;
`endif
    for (int t = 0; t < NTAP; t++) begin
      pend_d[t]       = pend_q[t];
      pend_abort_d[t] = pend_abort_q[t];
      pend_len_d[t]   = pend_len_q[t];
      if (complete[t]) begin
        if (pend_q[t] && !grant[t]) begin
`ifdef PKTCOLLECT_DROPCNT_EN
          drop[t] = 1'b1;
`endif
        end else begin
          pend_d[t]       = 1'b1;
          pend_abort_d[t] = i_tap_abort[t];
          pend_len_d[t]   = rec_len[t];
        end
      end else if (grant[t]) begin
        pend_d[t] = 1'b0;
      end
    end
  end

  // Output register: granted record for one cycle, zero otherwise
  always_comb begin
    out_valid_d = gnt_any;
    out_data_d  = '0;
    if (gnt_any) begin
      out_data_d = {2'b00, 1'b1, gnt_idx, 6'b0, pend_abort_q[gnt_idx], pend_len_q[gnt_idx], 2'b00};
    end
  end

`ifdef PKTCOLLECT_DROPCNT_EN
  // Saturating count of discarded records; several taps may drop in one cycle
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int t = 0; t < NTAP; t++) begin
      drop_sum = drop_sum + 17'(drop[t]);
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  assign o_dropped = drop_cnt_q;
`else
  assign o_dropped = '0;
`endif

  // State registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int t = 0; t < NTAP; t++) begin
        len_q[t]      <= '0;
        pend_len_q[t] <= '0;
      end
      inpkt_q      <= '0;
      pend_q       <= '0;
      pend_abort_q <= '0;
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
`ifdef PKTCOLLECT_DROPCNT_EN
      drop_cnt_q   <= '0;
`endif
    end else begin
      for (int t = 0; t < NTAP; t++) begin
        len_q[t]      <= len_d[t];
        pend_len_q[t] <= pend_len_d[t];
      end
      inpkt_q      <= inpkt_d;
      pend_q       <= pend_d;
      pend_abort_q <= pend_abort_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
`ifdef PKTCOLLECT_DROPCNT_EN
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;

endmodule

// File: tb/tb_pktstat_collect.sv
// tb/tb_pktstat_collect.sv - scoreboard bench for pktstat_collect (honours PKTCOLLECT_DROPCNT_EN)
module tb_pktstat_collect;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [3:0]  i_tap_valid, i_tap_ready, i_tap_last, i_tap_abort;
  logic [15:0] i_tap_bytes;
  logic        o_valid;
  logic [30:0] o_data;
  logic [15:0] o_dropped;

  typedef struct {
    logic [30:0] d;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

`ifdef PKTCOLLECT_DROPCNT_EN
  localparam int EXP_DROPS = 3;
`else
  localparam int EXP_DROPS = 0;
`endif

  pktstat_collect #(.DW(128)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_tap_valid (i_tap_valid),
    .i_tap_ready (i_tap_ready),
    .i_tap_last  (i_tap_last),
    .i_tap_abort (i_tap_abort),
    .i_tap_bytes (i_tap_bytes),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_dropped   (o_dropped)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cycle <= cycle + 1;

  function automatic logic [30:0] rec(input int tap, input logic ab, input int len);
    logic [16:0] l;
    logic [1:0]  s;
    l = 17'(len);
    s = 2'(tap);
    return {2'b00, 1'b1, s, 6'b0, ab, l, 2'b00};
  endfunction

  task automatic push(input logic [30:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of tap inputs, then advance to just after the next rising edge
  task automatic cyc(input logic [3:0] v, input logic [3:0] r, input logic [3:0] l,
                     input logic [3:0] a, input logic [15:0] b);
    i_tap_valid = v;
    i_tap_ready = r;
    i_tap_last  = l;
    i_tap_abort = a;
    i_tap_bytes = b;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      idle(1);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d records outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(4);
  endtask

  task automatic check_reset_state();
    checks++;
    if (o_valid !== 1'b0 || o_data !== 31'h0 || o_dropped !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h dropped=%0d, required 0/0/0", o_valid, o_data, o_dropped);
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #3;
    check_reset_state();
    idle(2);
    check_reset_state();
    i_reset_n = 1'b1;
    idle(1);
  endtask

  // Monitor: pops the scoreboard whenever a record strobes
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_reset_n === 1'b1) begin
        if (o_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record: data=%h at cycle %0d, required no record", o_data, cycle);
          end else begin
            e = exp_q.pop_front();
            if (o_data !== e.d) begin
              errors++;
              $display("FAIL record_data: got %h, required %h", o_data, e.d);
            end else if (e.c >= 0 && cycle != e.c) begin
              errors++;
              $display("FAIL record_latency: cycle %0d, required %0d", cycle, e.c);
            end
          end
        end else if (o_data !== 31'h0) begin
          checks++;
          errors++;
          $display("FAIL idle_data: got %h, required 0", o_data);
        end
      end
    end
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_tap_valid = '0;
    i_tap_ready = '0;
    i_tap_last  = '0;
    i_tap_abort = '0;
    i_tap_bytes = '0;
    fork
      monitor();
    join_none
    #2;
    do_reset();

    // Single packet on tap 0: 16 + 16 + 4, with one unaccepted beat in between
    cyc(4'h1, 4'h1, 4'h0, 4'h0, 16'h0000);
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 16'h0008);
    cyc(4'h1, 4'h1, 4'h0, 4'h0, 16'h0000);
    push(31'h1000_0090, cycle + 2);
    cyc(4'h1, 4'h1, 4'h1, 4'h0, 16'h0004);
    drain();

    // Abort on tap 1 with valid low, held two cycles; idle abort on tap 0
    cyc(4'h2, 4'h2, 4'h0, 4'h0, 16'h0000);
    push(31'h1408_0040, cycle + 2);
    cyc(4'h0, 4'h0, 4'h0, 4'h2, 16'h0000);
    cyc(4'h0, 4'h0, 4'h0, 4'h2, 16'h0000);
    cyc(4'h0, 4'h0, 4'h0, 4'h1, 16'h0000);
    drain();

    // Abort coinciding with an accepted last beat on tap 2: 8 + 4 bytes
    cyc(4'h4, 4'h4, 4'h0, 4'h0, 16'h0800);
    push(31'h1808_0030, -1);
    cyc(4'h4, 4'h4, 4'h4, 4'h4, 16'h0400);
    drain();

    // Length saturation on tap 2
    for (int i = 0; i < 8200; i++) cyc(4'h4, 4'h4, 4'h0, 4'h0, 16'h0000);
    push(31'h1807_FFFC, -1);
    cyc(4'h4, 4'h4, 4'h4, 4'h0, 16'h0000);
    drain();

    // Simultaneous 64-byte completions from pointer 0, then from pointer 1
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'hF, 4'hF, 4'h0, 4'h0, 16'h0000);
    push(rec(0, 1'b0, 64), -1);
    push(rec(1, 1'b0, 64), -1);
    push(rec(2, 1'b0, 64), -1);
    push(rec(3, 1'b0, 64), -1);
    cyc(4'hF, 4'hF, 4'hF, 4'h0, 16'h0000);
    drain();
    push(rec(0, 1'b0, 16), -1);
    cyc(4'h1, 4'h1, 4'h1, 4'h0, 16'h0000);
    drain();
    for (int i = 0; i < 3; i++) cyc(4'hF, 4'hF, 4'h0, 4'h0, 16'h0000);
    push(rec(1, 1'b0, 64), -1);
    push(rec(2, 1'b0, 64), -1);
    push(rec(3, 1'b0, 64), -1);
    push(rec(0, 1'b0, 64), -1);
    cyc(4'hF, 4'hF, 4'hF, 4'h0, 16'h0000);
    drain();

    // Collision: tap 3 completes every cycle while its slot waits behind taps 0-2
    do_reset();
    push(rec(0, 1'b0, 16), -1);
    push(rec(1, 1'b0, 16), -1);
    push(rec(2, 1'b0, 16), -1);
    push(rec(3, 1'b0, 16), -1);
    push(rec(3, 1'b0, 16), -1);
    cyc(4'hF, 4'hF, 4'hF, 4'h0, 16'h0000);
    for (int i = 0; i < 4; i++) cyc(4'h8, 4'h8, 4'h8, 4'h0, 16'h0000);
    drain();
    checks++;
    if (o_dropped !== 16'(EXP_DROPS)) begin
      errors++;
      $display("FAIL dropped_count: got %0d, required %0d", o_dropped, EXP_DROPS);
    end

    // Reset mid-packet on tap 0, then a fresh 8-byte packet
    cyc(4'h1, 4'h1, 4'h0, 4'h0, 16'h0000);
    cyc(4'h1, 4'h1, 4'h0, 4'h0, 16'h0000);
    do_reset();
    push(rec(0, 1'b0, 8), -1);
    cyc(4'h1, 4'h1, 4'h1, 4'h0, 16'h0008);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pktstat_collect.md
# pktstat_collect

Per-tap packet monitor and record serializer feeding the `pktstats` counter block. It passively watches four packet-stream taps: RX, post-CRC, TX and gate. For each tap it accumulates the byte length of every packet and builds one 31-bit statistics record when the packet completes or aborts. A round-robin arbiter merges the four record streams onto a single valid-only (no ready) output that connects directly to the `pktstats` `i_valid`/`i_data` inputs.

## Interface
- `DW`, default 128: tap data width in bits; bytes-per-beat field width is `BW = $clog2(DW/8)`.
- `NTAP`, fixed 4: number of taps; tap index maps to the record source code.
- `i_clk` input 1: sole clock.
- `i_reset_n` input 1: asynchronous, active-low reset.
- `i_tap_valid` input 4: per-tap beat valid (bit 0 RX, 1 CRC, 2 TX, 3 gate).
- `i_tap_ready` input 4: per-tap sink ready; a beat is accepted when valid && ready.
- `i_tap_last` input 4: per-tap last-beat flag, qualified by beat acceptance.
- `i_tap_abort` input 4: per-tap abort; honoured with or without valid.
- `i_tap_bytes` input 4*BW: per-tap byte count of the beat; 0 encodes DW/8.
- `o_valid` output 1: record strobe, one cycle per record.
- `o_data` output 31: record word.
- `o_dropped` output 16: saturating count of records lost to pending collision (see Configuration).

## Operation
- **Per-tap accumulator**
  - 17-bit `len` and `inpkt` flag.
  - On an accepted beat, `len` adds the decoded bytes, saturating at 17'h1FFFF, and `inpkt` is set.
- **Completion** occurs on an accepted beat with last, or on abort while `inpkt` or with an accepted beat.
  - The record is latched into the tap's single-entry pending register.
  - `len` clears to 0 and `inpkt` clears.
- **Abort rules**
  - An abort that coincides with an accepted last beat produces an abort record; its length includes that beat.
  - Abort while idle (not `inpkt`, no accepted beat) is ignored.
  - Abort held for several cycles produces one record.
  - Beats after an abort start a new packet.
- **Record format**
  - [30:29] = 0
  - [28] = 1
  - [27:26] = tap index
  - [25:20] = 0
  - [19] = abort
  - [18:2] = len, where an abort record carries the bytes counted so far
  - [1:0] = 0
- **Pending register**
  - Set on completion, cleared when granted.
  - Completion on the same cycle the entry is granted refills the entry and is not a drop.
  - Completion while the entry is full and not granted discards the new record and increments the drop counter. The older record is kept.
- **Arbiter**
  - Round-robin pointer with reset value 0.
  - Each cycle, grants the first pending tap at or after the pointer, wrapping.
  - On a grant, pointer ← granted+1 mod 4.
  - At most one grant per cycle.
- **Output**
  - The output register loads the granted record and pulses `o_valid`.
  - `o_data` is 0 whenever `o_valid` is low.
- **Reset**
  - Asynchronous assertion clears all accumulators, pending registers, the pointer and the drop counter, and zeroes `o_valid`, `o_data` and `o_dropped`.
  - A partially received packet at reset produces no record.

## Timing
- Last/abort beat at cycle N → pending set at N+1 → `o_valid` at N+2 when uncontended.
- With all four taps pending simultaneously, records emerge on consecutive cycles in pointer order. Worst-case wait is 3 extra cycles.
- Throughput is one record per cycle.
- There is no backpressure: `o_valid` is never held, and `i_tap_ready` is only observed.

## Configuration
- `PKTCOLLECT_DROPCNT_EN`
  - Defined: `o_dropped` is a 16-bit counter, incremented once per discarded record and saturating at 16'hFFFF. It is cleared only by reset.
  - Undefined: collisions still discard the new record, but no counter is built and `o_dropped` is tied to 0.

## Test plan
- **Single packet:** tap 0, three beats with bytes 0, 0, 4 (DW=128) and last on beat 3 → two cycles after the last beat, one `o_valid` with `o_data` = 31'h1000_0090 (len 36, [28]=1, src 0).
- **Abort:** tap 1, one 16-byte beat, then abort with valid low → `o_data` = 31'h1408_0040 (abort bit set, len 16). A second abort cycle produces no record.
- **Simultaneous completion:** all four taps complete 64-byte packets on the same cycle → four consecutive records, source 0, 1, 2, 3. Next simultaneous burst after pointer=1 gives order 1, 2, 3, 0.
- **Collision:** tap 3 receives 1-beat packets every cycle while taps 0–2 stay pending → tap 3 drops counted. With `PKTCOLLECT_DROPCNT_EN`, `o_dropped` matches the count of discarded records; without it, `o_dropped` = 0.
- **Saturation:** tap 2, 8200 full 16-byte beats then last → len field = 17'h1FFFF.
- **Reset mid-packet:** `i_reset_n` driven low mid-packet on tap 0, then a new 1-beat 8-byte packet → only one record emitted, len 8.
